// File: rtl/vuvmu_ctrl_ut_store_pipe.sv
// Unit-stride/indexed store pipe for the vector memory unit.
// Accepts one store or AMO command, then walks its elements. Each element
// combines store data, a per-element byte offset and (for AMOs) a reorder-queue
// tag into one store-request entry. Entries pass through a single output
// register before they reach the store request queue.
// Optional build macro: VMU_STORE_MISALIGN_CHK_EN. When it is defined,
// misaligned elements are dropped and a sticky misalign_fault flag is raised.
module vuvmu_ctrl_ut_store_pipe #(
  parameter int ADDR_W = 32,
  parameter int VLEN_W = 11,
  parameter int TAG_W  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1+5+ADDR_W+VLEN_W-1:0]  stcmdq_deq_bits,
  input  logic                          stcmdq_deq_val,
  output logic                          stcmdq_deq_rdy,
  input  logic [63:0]                   sdq_deq_bits,
  input  logic                          sdq_deq_val,
  output logic                          sdq_deq_rdy,
  input  logic [ADDR_W-1:0]             utaq_deq_bits,
  input  logic                          utaq_deq_val,
  output logic                          utaq_deq_rdy,
  input  logic [TAG_W-1:0]              roq_deq_tag_bits,
  input  logic                          roq_deq_tag_val,
  output logic                          roq_deq_tag_rdy,
  output logic [ADDR_W-4:0]             srq_enq_addr_bits,
  output logic [TAG_W+3:0]              srq_enq_tag_bits,
  output logic [3:0]                    srq_enq_op_bits,
  output logic [63:0]                   srq_enq_data_bits,
  output logic [7:0]                    srq_enq_wmask_bits,
  output logic                          srq_enq_val,
  input  logic                          srq_enq_rdy,
  output logic                          cmd_done,
  output logic                          misalign_fault,
  output logic                          store_busy
);

  localparam int CMD_W = 1 + 5 + ADDR_W + VLEN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    AMO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [4:0]        type_reg;
  logic [VLEN_W-1:0] vlen_reg;
  logic [VLEN_W-1:0] cnt_reg;
  logic [ADDR_W-1:0] base_reg;

  logic              cmd_amo;
  logic [4:0]        cmd_type;
  logic [ADDR_W-1:0] cmd_base;
  logic [VLEN_W-1:0] cmd_vlen;
  logic              cmd_accept;

  logic              active;
  logic              in_amo;
  logic              tag_ok;
  logic              slot_free;
  logic              fire_p0;
  logic              issue_p0;
  logic              last_p0;

  logic [ADDR_W-1:0] elem_addr_p0;
  logic [TAG_W+3:0]  tag_p0;
  logic [3:0]        op_p0;
  logic [63:0]       data_p0;
  logic [7:0]        wmask_p0;

  logic              vld_p1;
  logic [ADDR_W-4:0] addr_p1;
  logic [TAG_W+3:0]  tag_p1;
  logic [3:0]        op_p1;
  logic [63:0]       data_p1;
  logic [7:0]        wmask_p1;

  // Replicate the LSB-aligned store datum across all eight byte lanes.
  function automatic logic [63:0] replicate_data(input logic [1:0] size, input logic [63:0] d);
    case (size)
      2'b00:   replicate_data = {8{d[7:0]}};
      2'b01:   replicate_data = {4{d[15:0]}};
      2'b10:   replicate_data = {2{d[31:0]}};
      default: replicate_data = d;
    endcase
  endfunction

  // Byte-lane write mask; the low address bits beyond the size alignment are ignored.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] a);
    case (size)
      2'b00:   lane_mask = 8'h01 << a;
      2'b01:   lane_mask = 8'h03 << {a[2:1], 1'b0};
      2'b10:   lane_mask = a[2] ? 8'hF0 : 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
  endfunction

  assign cmd_amo  = stcmdq_deq_bits[CMD_W-1];
  assign cmd_type = stcmdq_deq_bits[CMD_W-2 -: 5];
  assign cmd_base = stcmdq_deq_bits[VLEN_W +: ADDR_W];
  assign cmd_vlen = stcmdq_deq_bits[VLEN_W-1:0];

  assign stcmdq_deq_rdy = (state_q == IDLE) && !reset;
  assign cmd_accept     = stcmdq_deq_rdy && stcmdq_deq_val;

  // Element handshake: every participating queue moves in the same cycle, and
  // each ready is raised only when all the other parties are able to move.
  assign in_amo    = (state_q == AMO);
  assign active    = ((state_q == STORE) || in_amo) && !reset;
  assign tag_ok    = in_amo ? roq_deq_tag_val : 1'b1;
  assign slot_free = !vld_p1 || srq_enq_rdy;

  assign sdq_deq_rdy     = active && utaq_deq_val && tag_ok && slot_free;
  assign utaq_deq_rdy    = active && sdq_deq_val && tag_ok && slot_free;
  assign roq_deq_tag_rdy = active && in_amo && sdq_deq_val && utaq_deq_val && slot_free;
  assign fire_p0         = active && sdq_deq_val && utaq_deq_val && tag_ok && slot_free;
  assign last_p0         = (cnt_reg == vlen_reg);
  assign cmd_done        = fire_p0 && last_p0;

  assign elem_addr_p0 = base_reg + utaq_deq_bits;
  assign tag_p0       = {4'h8, (in_amo ? roq_deq_tag_bits : {TAG_W{1'b0}})};
  assign op_p0        = in_amo ? {1'b1, type_reg[4:2]} : 4'b0001;
  assign data_p0      = replicate_data(type_reg[1:0], sdq_deq_bits);
  assign wmask_p0     = lane_mask(type_reg[1:0], elem_addr_p0[2:0]);

`ifdef VMU_STORE_MISALIGN_CHK_EN
  logic misalign_p0;
  logic fault_reg;

  // An element is misaligned when any address bit below its size is set.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = |a[1:0];
      default: is_misaligned = |a;
    endcase
  endfunction

  assign misalign_p0    = is_misaligned(type_reg[1:0], elem_addr_p0[2:0]);
  assign issue_p0       = fire_p0 && !misalign_p0;
  assign misalign_fault = fault_reg;

  // Sticky fault: cleared when a new command is taken, set by a dropped element.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_reg <= 1'b0;
    end else if (cmd_accept) begin
      fault_reg <= 1'b0;
    end else if (fire_p0 && misalign_p0) begin
      fault_reg <= 1'b1;
    end
  end
`else
  assign issue_p0       = fire_p0;
  assign misalign_fault = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: take a command in IDLE, return to IDLE on the last element.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (stcmdq_deq_val) begin
          state_d = cmd_amo ? AMO : STORE;
        end
      end
      STORE, AMO: begin
        if (fire_p0 && last_p0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command registers and element counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      type_reg <= '0;
      vlen_reg <= '0;
      base_reg <= '0;
      cnt_reg  <= '0;
    end else if (cmd_accept) begin
      type_reg <= cmd_type;
      vlen_reg <= cmd_vlen;
      base_reg <= cmd_amo ? {ADDR_W{1'b0}} : cmd_base;
      cnt_reg  <= '0;
    end else if (fire_p0 && !last_p0) begin
      cnt_reg  <= cnt_reg + {{(VLEN_W-1){1'b0}}, 1'b1};
    end
  end

  // ---- p0 -> p1: output register stage ----
  // Valid bit of the single-entry output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (issue_p0) begin
      vld_p1 <= 1'b1;
    end else if (srq_enq_rdy) begin
      vld_p1 <= 1'b0;
    end
  end

  // Payload of the output register; only meaningful while vld_p1 is set.
  always_ff @(posedge clk) begin
    if (issue_p0) begin
      addr_p1  <= elem_addr_p0[ADDR_W-1:3];
      tag_p1   <= tag_p0;
      op_p1    <= op_p0;
      data_p1  <= data_p0;
      wmask_p1 <= wmask_p0;
    end
  end

  assign srq_enq_val        = vld_p1;
  assign srq_enq_addr_bits  = addr_p1;
  assign srq_enq_tag_bits   = tag_p1;
  assign srq_enq_op_bits    = op_p1;
  assign srq_enq_data_bits  = data_p1;
  assign srq_enq_wmask_bits = wmask_p1;

  assign store_busy = (state_q != IDLE) || vld_p1 || stcmdq_deq_val;

endmodule

// File: tb/tb_vuvmu_ctrl_ut_store_pipe.sv
// Self-checking bench for vuvmu_ctrl_ut_store_pipe: directed commands, a
// request-level model of the expected store stream, and literal spot checks.
module tb_vuvmu_ctrl_ut_store_pipe;

  localparam int AW = 32;
  localparam int VW = 11;
  localparam int TW = 8;

`ifdef VMU_STORE_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [1+5+AW+VW-1:0] stcmdq_deq_bits;
  logic               stcmdq_deq_val;
  logic               stcmdq_deq_rdy;
  logic [63:0]        sdq_deq_bits;
  logic               sdq_deq_val;
  logic               sdq_deq_rdy;
  logic [AW-1:0]      utaq_deq_bits;
  logic               utaq_deq_val;
  logic               utaq_deq_rdy;
  logic [TW-1:0]      roq_deq_tag_bits;
  logic               roq_deq_tag_val;
  logic               roq_deq_tag_rdy;
  logic [AW-4:0]      srq_enq_addr_bits;
  logic [TW+3:0]      srq_enq_tag_bits;
  logic [3:0]         srq_enq_op_bits;
  logic [63:0]        srq_enq_data_bits;
  logic [7:0]         srq_enq_wmask_bits;
  logic               srq_enq_val;
  logic               srq_enq_rdy;
  logic               cmd_done;
  logic               misalign_fault;
  logic               store_busy;

  vuvmu_ctrl_ut_store_pipe #(.ADDR_W(AW), .VLEN_W(VW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .stcmdq_deq_bits(stcmdq_deq_bits), .stcmdq_deq_val(stcmdq_deq_val), .stcmdq_deq_rdy(stcmdq_deq_rdy),
    .sdq_deq_bits(sdq_deq_bits), .sdq_deq_val(sdq_deq_val), .sdq_deq_rdy(sdq_deq_rdy),
    .utaq_deq_bits(utaq_deq_bits), .utaq_deq_val(utaq_deq_val), .utaq_deq_rdy(utaq_deq_rdy),
    .roq_deq_tag_bits(roq_deq_tag_bits), .roq_deq_tag_val(roq_deq_tag_val), .roq_deq_tag_rdy(roq_deq_tag_rdy),
    .srq_enq_addr_bits(srq_enq_addr_bits), .srq_enq_tag_bits(srq_enq_tag_bits),
    .srq_enq_op_bits(srq_enq_op_bits), .srq_enq_data_bits(srq_enq_data_bits),
    .srq_enq_wmask_bits(srq_enq_wmask_bits), .srq_enq_val(srq_enq_val), .srq_enq_rdy(srq_enq_rdy),
    .cmd_done(cmd_done), .misalign_fault(misalign_fault), .store_busy(store_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-4:0] addr;
    logic [TW+3:0] tag;
    logic [3:0]    op;
    logic [63:0]   data;
    logic [7:0]    wm;
  } req_t;

  req_t          exp_q[$];
  req_t          obs[32];
  int            obs_n = 0;
  int            checks = 0;
  int            failures = 0;
  bit            cur_amo = 1'b0;
  bit            exp_last = 1'b0;
  logic          exp_fault = 1'b0;
  logic [AW-1:0] off_a[16];
  logic [63:0]   dat_a[16];
  logic [TW-1:0] tag_a[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic bit is_mis(input logic [1:0] sz, input logic [2:0] a);
    int nb = 1 << sz;
    return (int'(a) % nb) != 0;
  endfunction

  // Expected request for one element, built lane by lane from the size rules.
  function automatic req_t model(input bit amo, input logic [4:0] typ, input logic [AW-1:0] base,
                                 input logic [AW-1:0] off, input logic [63:0] d, input logic [TW-1:0] t);
    req_t r;
    logic [AW-1:0] a;
    int nb, st;
    a      = (amo ? '0 : base) + off;
    nb     = 1 << typ[1:0];
    st     = (int'(a[2:0]) / nb) * nb;
    r.addr = a[AW-1:3];
    r.tag  = {4'h8, (amo ? t : {TW{1'b0}})};
    r.op   = amo ? {1'b1, typ[4:2]} : 4'b0001;
    for (int j = 0; j < 8; j++) begin
      r.data[j*8 +: 8] = d[(j % nb)*8 +: 8];
      r.wm[j]          = (j >= st) && (j < st + nb);
    end
    return r;
  endfunction

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one command and feed its n elements from off_a/dat_a/tag_a.
  task automatic run_cmd(input bit amo, input logic [4:0] typ, input logic [AW-1:0] base, input int n);
    int w;
    bit got;
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = (amo ? '0 : base) + off_a[i];
      if (!(MIS_EN && is_mis(typ[1:0], a[2:0])))
        exp_q.push_back(model(amo, typ, base, off_a[i], dat_a[i], tag_a[i]));
    end
    stcmdq_deq_bits = {amo, typ, base, VW'(n - 1)};
    stcmdq_deq_val  = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      got = stcmdq_deq_rdy;
      @(posedge clk);
      #1;
      w++;
    end while (!got && w < 100);
    stcmdq_deq_val = 1'b0;
    if (!got) chk("cmd_accept_timeout", 0, 1);
    exp_fault = 1'b0;
    cur_amo   = amo;
    for (int i = 0; i < n; i++) begin
      sdq_deq_bits     = dat_a[i];
      utaq_deq_bits    = off_a[i];
      roq_deq_tag_bits = tag_a[i];
      sdq_deq_val      = 1'b1;
      utaq_deq_val     = 1'b1;
      roq_deq_tag_val  = amo;
      exp_last         = (i == n - 1);
      w = 0;
      do begin
        @(negedge clk);
        got = sdq_deq_rdy && sdq_deq_val;
        @(posedge clk);
        #1;
        w++;
      end while (!got && w < 100);
      if (!got) chk("elem_accept_timeout", 0, 1);
      a = (amo ? '0 : base) + off_a[i];
      if (MIS_EN && is_mis(typ[1:0], a[2:0])) exp_fault = 1'b1;
    end
    sdq_deq_val     = 1'b0;
    utaq_deq_val    = 1'b0;
    roq_deq_tag_val = 1'b0;
    exp_last        = 1'b0;
    cur_amo         = 1'b0;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  initial begin
    req_t e, cur, prev_req;
    bit prev_stall = 1'b0;
    bit prev_rst   = 1'b1;
    bit hs_s, hs_u, hs_r;
    forever begin
      @(negedge clk);
      cur = {srq_enq_addr_bits, srq_enq_tag_bits, srq_enq_op_bits, srq_enq_data_bits, srq_enq_wmask_bits};
      if (!reset) begin
        if (srq_enq_val && srq_enq_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_req", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("req_addr", 64'(cur.addr), 64'(e.addr));
            chk("req_tag", 64'(cur.tag), 64'(e.tag));
            chk("req_op", 64'(cur.op), 64'(e.op));
            chk("req_data", cur.data, e.data);
            chk("req_wmask", 64'(cur.wm), 64'(e.wm));
          end
          if (obs_n < 32) begin
            obs[obs_n] = cur;
            obs_n++;
          end
        end
        if (srq_enq_val && !srq_enq_rdy)
          chk("stall_deq_rdy", {61'd0, sdq_deq_rdy, utaq_deq_rdy, roq_deq_tag_rdy}, 0);
        if (prev_stall && !prev_rst) begin
          chk("hold_val", 64'(srq_enq_val), 1);
          chk("hold_payload", 64'(cur == prev_req), 1);
        end
        hs_s = sdq_deq_val && sdq_deq_rdy;
        hs_u = utaq_deq_val && utaq_deq_rdy;
        hs_r = roq_deq_tag_val && roq_deq_tag_rdy;
        chk("lockstep_sdq_utaq", 64'(hs_s), 64'(hs_u));
        chk("lockstep_roq", 64'(hs_r), 64'(cur_amo && hs_s));
        chk("cmd_done", 64'(cmd_done), 64'(hs_u && exp_last));
        chk("misalign_fault", 64'(misalign_fault), 64'(exp_fault));
      end
      prev_stall = srq_enq_val && !srq_enq_rdy && !reset;
      prev_req   = cur;
      prev_rst   = reset;
    end
  end

  initial begin
    reset = 1'b1;
    stcmdq_deq_bits = '0; stcmdq_deq_val = 1'b0;
    sdq_deq_bits = '0; sdq_deq_val = 1'b0;
    utaq_deq_bits = '0; utaq_deq_val = 1'b0;
    roq_deq_tag_bits = '0; roq_deq_tag_val = 1'b0;
    srq_enq_rdy = 1'b0;
    foreach (off_a[i]) begin off_a[i] = '0; dat_a[i] = '0; tag_a[i] = '0; end
    idle(3);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_srq_val", 64'(srq_enq_val), 0);
    chk("rst_stcmdq_rdy", 64'(stcmdq_deq_rdy), 1);
    chk("rst_deq_rdys", {61'd0, sdq_deq_rdy, utaq_deq_rdy, roq_deq_tag_rdy}, 0);
    chk("rst_cmd_done", 64'(cmd_done), 0);
    chk("rst_fault", 64'(misalign_fault), 0);
    chk("rst_busy", 64'(store_busy), 0);
    @(posedge clk); #1;
    srq_enq_rdy = 1'b1;

    // Word store, base 0x1000, offsets 0,4,8,12
    obs_n = 0;
    for (int i = 0; i < 4; i++) begin
      off_a[i] = AW'(i * 4);
      dat_a[i] = 64'h0000_0000_CAFE_F000 + 64'(i);
    end
    run_cmd(1'b0, 5'b00010, 32'h0000_1000, 4);
    idle(3);
    chk("word_count", 64'(obs_n), 4);
    chk("word_addr0", 64'(obs[0].addr), 64'h200);
    chk("word_addr1", 64'(obs[1].addr), 64'h200);
    chk("word_addr2", 64'(obs[2].addr), 64'h201);
    chk("word_addr3", 64'(obs[3].addr), 64'h201);
    chk("word_wm0", 64'(obs[0].wm), 64'h0F);
    chk("word_wm1", 64'(obs[1].wm), 64'hF0);
    chk("word_wm2", 64'(obs[2].wm), 64'h0F);
    chk("word_wm3", 64'(obs[3].wm), 64'hF0);
    chk("word_data1", obs[1].data, 64'hCAFEF001_CAFEF001);
    chk("word_tag0", 64'(obs[0].tag), 64'h800);
    chk("word_op0", 64'(obs[0].op), 64'h1);
    chk("idle_busy", 64'(store_busy), 0);

    // AMO, type 10111, tags 0x11,0x12; base field must be ignored
    obs_n = 0;
    off_a[0] = 32'h40; dat_a[0] = 64'h0123_4567_89AB_CDEF; tag_a[0] = 8'h11;
    off_a[1] = 32'h48; dat_a[1] = 64'hFEDC_BA98_7654_3210; tag_a[1] = 8'h12;
    run_cmd(1'b1, 5'b10111, 32'h0000_5000, 2);
    idle(3);
    chk("amo_count", 64'(obs_n), 2);
    chk("amo_op0", 64'(obs[0].op), 64'hD);
    chk("amo_op1", 64'(obs[1].op), 64'hD);
    chk("amo_tag0", 64'(obs[0].tag), 64'h811);
    chk("amo_tag1", 64'(obs[1].tag), 64'h812);
    chk("amo_addr1", 64'(obs[1].addr), 64'h9);
    chk("amo_wm0", 64'(obs[0].wm), 64'hFF);

    // Double store with a 5-cycle output stall mid-stream
    obs_n = 0;
    for (int i = 0; i < 8; i++) begin
      off_a[i] = AW'(i * 8);
      dat_a[i] = {$urandom, $urandom};
    end
    fork
      run_cmd(1'b0, 5'b00011, 32'h0000_2000, 8);
      begin
        idle(5);
        srq_enq_rdy = 1'b0;
        idle(5);
        srq_enq_rdy = 1'b1;
      end
    join
    idle(3);
    chk("stall_count", 64'(obs_n), 8);
    chk("stall_addr7", 64'(obs[7].addr), 64'h407);

    // Byte store at offset 7
    obs_n = 0;
    off_a[0] = 32'h7; dat_a[0] = 64'hAB;
    run_cmd(1'b0, 5'b00000, 32'h0, 1);
    idle(3);
    chk("byte_count", 64'(obs_n), 1);
    chk("byte_wm", 64'(obs[0].wm), 64'h80);
    chk("byte_data", obs[0].data, 64'hABAB_ABAB_ABAB_ABAB);

    // Misaligned half store at offset 1
    obs_n = 0;
    off_a[0] = 32'h1; dat_a[0] = 64'h5A5A;
    run_cmd(1'b0, 5'b00001, 32'h0, 1);
    idle(3);
    chk("mis_count", 64'(obs_n), MIS_EN ? 0 : 1);
    if (!MIS_EN) chk("mis_wm", 64'(obs[0].wm), 64'h03);
    chk("mis_fault_sticky", 64'(misalign_fault), 64'(MIS_EN));

    // Aligned half store at offset 6 clears the fault
    obs_n = 0;
    off_a[0] = 32'h6; dat_a[0] = 64'h1234;
    run_cmd(1'b0, 5'b00001, 32'h0, 1);
    idle(3);
    chk("half_wm", 64'(obs[0].wm), 64'hC0);
    chk("half_data", obs[0].data, 64'h1234_1234_1234_1234);
    chk("fault_cleared", 64'(misalign_fault), 0);

    // Reset with two elements remaining and the output register full
    obs_n = 0;
    srq_enq_rdy = 1'b0;
    stcmdq_deq_bits = {1'b0, 5'b00011, 32'h0, 11'd2};
    stcmdq_deq_val  = 1'b1;
    @(posedge clk); #1;
    stcmdq_deq_val = 1'b0;
    sdq_deq_bits = 64'h1111_2222_3333_4444; utaq_deq_bits = '0;
    sdq_deq_val = 1'b1; utaq_deq_val = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_buffer_full", 64'(srq_enq_val), 1);
    chk("pre_rst_sdq_blocked", 64'(sdq_deq_rdy), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    sdq_deq_val = 1'b0; utaq_deq_val = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_srq_val", 64'(srq_enq_val), 0);
    chk("post_rst_stcmdq_rdy", 64'(stcmdq_deq_rdy), 1);
    chk("post_rst_busy", 64'(store_busy), 0);
    @(posedge clk); #1;
    srq_enq_rdy = 1'b1;
    idle(2);
    chk("post_rst_no_stale", 64'(obs_n), 0);
    off_a[0] = 32'h10; dat_a[0] = 64'h9999_8888_7777_6666;
    run_cmd(1'b0, 5'b00011, 32'h0, 1);
    idle(3);
    chk("post_rst_clean_cmd", 64'(obs_n), 1);
    chk("post_rst_addr", 64'(obs[0].addr), 64'h2);

    chk("exp_q_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
